// File: rtl/sobel_frame_ctrl_if.sv
// Handshake bundle of sobel_frame_ctrl: frame control, pixel source, Sobel datapath link and edge sink.
// master = controller side, slave = environment (source, datapath, sink, sequencer).
interface sobel_frame_ctrl_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_pixel;
  logic [7:0] pix_out;
  logic       pix_en;
  logic [7:0] edge_in;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_edge;
  logic       m_sof;
  logic       m_eof;

  modport master (
    input  start, s_valid, s_pixel, edge_in, m_ready,
    output busy, done, s_ready, pix_out, pix_en, m_valid, m_edge, m_sof, m_eof
  );

  modport slave (
    output start, s_valid, s_pixel, edge_in, m_ready,
    input  busy, done, s_ready, pix_out, pix_en, m_valid, m_edge, m_sof, m_eof
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer feeding a Sobel datapath and forwarding interior edges with sof/eof framing.
// Define SOBEL_CTRL_FRAME_CNT_EN to add the 16-bit frame_cnt output (completed-frame counter).
module sobel_frame_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  sobel_frame_ctrl_if.master bus
`ifdef SOBEL_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);
  localparam int EDGES = (IMG_W - 2) * (IMG_H - 2);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int ECW   = $clog2(EDGES + 1);
  localparam int FW    = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [FW-1:0]         flush_q, flush_d;
  logic [ECW-1:0]        edge_cnt_q, edge_cnt_d;
  logic [PIPE_LAT-1:0]   tag_q, tag_d;
  logic                  m_valid_q, m_valid_d;
  logic [7:0]            m_edge_q, m_edge_d;
  logic                  m_sof_q, m_sof_d;
  logic                  m_eof_q, m_eof_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic adv, s_ready, accept, pix_en, new_tag, tag_exit;

  // Datapath and source only move when the output register can take a result.
  always_comb begin
    adv      = !m_valid_q || bus.m_ready;
    s_ready  = (state_q == RUN) && adv;
    accept   = s_ready && bus.s_valid;
    case (state_q)
      RUN:     pix_en = accept;
      FLUSH:   pix_en = adv;
      default: pix_en = 1'b0;
    endcase
    new_tag  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    tag_exit = pix_en && tag_q[PIPE_LAT-1];
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    flush_d    = flush_q;
    edge_cnt_d = edge_cnt_q;
    tag_d      = tag_q;
    m_valid_d  = m_valid_q;
    m_edge_d   = m_edge_q;
    m_sof_d    = m_sof_q;
    m_eof_d    = m_eof_q;

    if (pix_en) begin
      tag_d[0] = new_tag;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = RUN;
          col_d      = '0;
          row_d      = '0;
          edge_cnt_d = '0;
          tag_d      = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            if (row_q == RW'(IMG_H - 1)) begin
              row_d   = '0;
              flush_d = '0;
              state_d = FLUSH;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          flush_d = flush_q + 1'b1;
          if (flush_q == FW'(PIPE_LAT - 1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new result may replace the one being handed off in the same cycle.
    if (tag_exit) begin
      m_valid_d  = 1'b1;
      m_edge_d   = bus.edge_in;
      m_sof_d    = (edge_cnt_q == '0);
      m_eof_d    = (edge_cnt_q == ECW'(EDGES - 1));
      edge_cnt_d = edge_cnt_q + 1'b1;
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
      m_sof_d   = 1'b0;
      m_eof_d   = 1'b0;
    end

    busy_d = (state_d == RUN) || (state_d == FLUSH);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      flush_q    <= '0;
      edge_cnt_q <= '0;
      tag_q      <= '0;
      m_valid_q  <= 1'b0;
      m_edge_q   <= '0;
      m_sof_q    <= 1'b0;
      m_eof_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      flush_q    <= flush_d;
      edge_cnt_q <= edge_cnt_d;
      tag_q      <= tag_d;
      m_valid_q  <= m_valid_d;
      m_edge_q   <= m_edge_d;
      m_sof_q    <= m_sof_d;
      m_eof_q    <= m_eof_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef SOBEL_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == DONE) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_cnt_q <= '0;
    else      frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign bus.s_ready = s_ready;
  assign bus.pix_en  = pix_en;
  assign bus.pix_out = accept ? bus.s_pixel : 8'h00;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_edge  = m_edge_q;
  assign bus.m_sof   = m_sof_q;
  assign bus.m_eof   = m_eof_q;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on a 4x4 image: a Sobel datapath model drives edge_in,
// expected edges come from a whole-frame reference, a monitor pops and compares on each handshake.
module tb_sobel_frame_ctrl;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 4;
  localparam int PIPE_LAT = 2;
  localparam int NPIX     = IMG_W * IMG_H;
  localparam int NEDGE    = (IMG_W - 2) * (IMG_H - 2);

  typedef struct packed {
    logic [7:0] edge_v;
    logic       sof;
    logic       eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sobel_frame_ctrl_if bus ();
`ifdef SOBEL_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  sobel_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIPE_LAT(PIPE_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SOBEL_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  int         checks   = 0;
  int         failures = 0;
  int         frames   = 0;
  int         mr_mode  = 0;
  logic       dp_clr   = 1'b0;
  exp_t       sb_q[$];
  logic [7:0] img[NPIX];
  logic [7:0] hist[NPIX];
  logic [7:0] pipe[PIPE_LAT];
  int         dp_k;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endfunction

  function automatic logic [7:0] sobel3(input logic [7:0] w[9]);
    int gx, gy, mag;
    gx = (int'(w[2]) + 2 * int'(w[5]) + int'(w[8])) - (int'(w[0]) + 2 * int'(w[3]) + int'(w[6]));
    gy = (int'(w[6]) + 2 * int'(w[7]) + int'(w[8])) - (int'(w[0]) + 2 * int'(w[1]) + int'(w[2]));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    mag = gx + gy;
    if (mag > 255) mag = 255;
    return 8'(mag);
  endfunction

  // Datapath model: result for stream pixel k is the Sobel of the 3x3 window ending at k;
  // windows that do not fit yield a recognisable junk value.
  function automatic logic [7:0] dp_edge(input int k, input logic [7:0] cur);
    logic [7:0] w[9];
    int r, c, idx;
    r = k / IMG_W;
    c = k % IMG_W;
    if (k >= NPIX || r < 2 || c < 2) return 8'hA5 ^ 8'(k);
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        idx = (r - 2 + dr) * IMG_W + (c - 2 + dc);
        w[dr*3+dc] = (idx == k) ? cur : hist[idx];
      end
    end
    return sobel3(w);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= 8'h00;
      dp_k <= 0;
    end else if (dp_clr) begin
      dp_k <= 0;
    end else if (bus.pix_en) begin
      if (dp_k < NPIX) hist[dp_k] <= bus.pix_out;
      for (int i = PIPE_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= dp_edge(dp_k, bus.pix_out);
      dp_k <= dp_k + 1;
    end
  end
  assign bus.edge_in = pipe[PIPE_LAT-1];

  // Reference: one edge per interior centre, raster order, framed by sof/eof.
  task automatic push_expected();
    logic [7:0] w[9];
    exp_t e;
    int n;
    n = 0;
    for (int r = 1; r < IMG_H - 1; r++) begin
      for (int c = 1; c < IMG_W - 1; c++) begin
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            w[(dr+1)*3 + dc + 1] = img[(r + dr) * IMG_W + c + dc];
        e.edge_v = sobel3(w);
        e.sof    = (n == 0);
        e.eof    = (n == NEDGE - 1);
        sb_q.push_back(e);
        n++;
      end
    end
  endtask

  // Sink: mode 0 always ready, mode 1 stalls 10 cycles after first edge, mode 2 random.
  initial begin : sink
    int stall_left;
    int last_mode;
    bit armed;
    stall_left  = 0;
    last_mode   = 0;
    armed       = 1'b0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mr_mode == 1 && last_mode != 1) armed = 1'b1;
      last_mode = mr_mode;
      if (stall_left > 0) begin
        bus.m_ready = 1'b0;
        stall_left--;
      end else begin
        bus.m_ready = (mr_mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (armed && bus.m_valid && bus.m_sof && bus.m_ready) begin
          armed      = 1'b0;
          stall_left = 10;
        end
      end
    end
  end

  initial begin : monitor
    bit   prev_stall;
    exp_t held, got, want;
    int   n_seen;
    prev_stall = 1'b0;
    held       = '0;
    n_seen     = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        got = {bus.m_edge, bus.m_sof, bus.m_eof};
        if (prev_stall) begin
          check("hold_valid", 32'(bus.m_valid), 32'd1);
          check("hold_data", 32'(got), 32'(held));
        end
        if (bus.m_valid && !bus.m_ready) begin
          check("stall_s_ready", 32'(bus.s_ready), 32'd0);
          check("stall_pix_en", 32'(bus.pix_en), 32'd0);
        end
        if (!bus.busy) check("idle_pix_en", 32'(bus.pix_en), 32'd0);
        if (bus.s_ready) check("pix_en_accept", 32'(bus.pix_en), 32'(bus.s_valid));
        if (bus.pix_en && bus.s_ready) check("pix_out", 32'(bus.pix_out), 32'(bus.s_pixel));
        if (bus.m_valid && bus.m_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_edge: got edge %02h sof=%0b eof=%0b, required no edge",
                     bus.m_edge, bus.m_sof, bus.m_eof);
          end else begin
            want = sb_q.pop_front();
            n_seen++;
            $display("edge %0d: m_edge=%02h sof=%0b eof=%0b (want %02h/%0b/%0b)",
                     n_seen, got.edge_v, got.sof, got.eof, want.edge_v, want.sof, want.eof);
            check("edge", 32'(got), 32'(want));
          end
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        held       = got;
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, {9'd0, bus.busy, bus.done, bus.s_ready, bus.pix_en, bus.pix_out,
                 bus.m_valid, bus.m_edge, bus.m_sof, bus.m_eof}, 32'd0);
  endtask

  task automatic apply_reset(input string name);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_pixel = 8'hFF;
    bus.start   = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(name);
    $display("reset %s applied", name);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    rst         = 1'b1;
    frames      = 0;
  endtask

  task automatic fill_img(input bit ramp);
    for (int i = 0; i < NPIX; i++) img[i] = ramp ? 8'(i) : 8'($urandom);
  endtask

  // sv_mode: 0 always valid, 1 every other cycle, 2 random. abort_at>0 stops feeding early.
  task automatic run_frame(input string name, input int sv_mode, input int abort_at, input bit start_mid);
    int idx, cyc, dcount, extra;
    bit pulsed;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    dp_clr    = 1'b1;
    push_expected();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dp_clr    = 1'b0;
    idx       = 0;
    cyc       = 0;
    pulsed    = 1'b0;
    while (idx < NPIX && cyc < 2000) begin
      if (abort_at > 0 && idx == abort_at) break;
      case (sv_mode)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = (cyc % 2 == 0);
        default: bus.s_valid = ($urandom_range(0, 3) != 0);
      endcase
      bus.s_pixel = img[idx];
      bus.start   = start_mid && (idx == 5) && !pulsed;
      if (bus.start) pulsed = 1'b1;
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) idx++;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc++;
    end
    bus.s_valid = 1'b0;
    if (abort_at > 0) begin
      check("abort_point", 32'(idx), 32'(abort_at));
      return;
    end
    check("pixels_accepted", 32'(idx), 32'(NPIX));
    dcount = 0;
    extra  = 0;
    cyc    = 0;
    while (cyc < 1000 && !(dcount > 0 && !bus.m_valid && extra >= 3)) begin
      @(negedge clk);
      if (bus.done) dcount++;
      if (dcount > 0) extra++;
      cyc++;
    end
    check("done_pulses", 32'(dcount), 32'd1);
    check("edges_outstanding", 32'(sb_q.size()), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
    frames++;
`ifdef SOBEL_CTRL_FRAME_CNT_EN
    check("frame_cnt", 32'(frame_cnt), 32'(frames));
`endif
    $display("frame %s complete", name);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    bus.start   = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_pixel = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    rst         = 1'b1;

    fill_img(1'b1);
    run_frame("ramp", 0, 0, 1'b0);
    mr_mode = 1;
    run_frame("ramp_sink_stall", 0, 0, 1'b0);
    mr_mode = 0;
    fill_img(1'b0);
    run_frame("rand_toggle_valid", 1, 0, 1'b0);

    fill_img(1'b0);
    run_frame("abort7", 0, 7, 1'b0);
    apply_reset("mid_frame_7");
    fill_img(1'b1);
    run_frame("after_abort", 0, 0, 1'b0);

    fill_img(1'b0);
    run_frame("start_in_run", 0, 0, 1'b1);

    fill_img(1'b0);
    run_frame("abort13", 2, 13, 1'b0);
    apply_reset("mid_frame_13");
    mr_mode = 2;
    for (int f = 0; f < 3; f++) begin
      fill_img(1'b0);
      run_frame("random", 2, 0, 1'b0);
    end
    mr_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 Parameter IMG_W, default 640, pixels per line (>=3).
REQ-002 Parameter IMG_H, default 480, lines per frame (>=3).
REQ-003 Parameter PIPE_LAT, default 2, cycles of pix_en from pixel presentation to matching edge_in (>=1).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 start  input  1  one-cycle frame-start pulse; honoured only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE and DONE.
REQ-008 done  output  1  one-cycle pulse on frame completion.
REQ-009 s_valid  input  1  source pixel valid.
REQ-010 s_ready  output  1  controller accepts s_pixel this cycle.
REQ-011 s_pixel  input  8  source pixel, raster order.
REQ-012 pix_out  output  8  pixel driven to Sobel datapath pixel_in.
REQ-013 pix_en  output  1  datapath advance strobe; datapath shifts only when high.
REQ-014 edge_in  input  8  datapath edge_out.
REQ-015 m_valid  output  1  edge output valid.
REQ-016 m_ready  input  1  sink accepts edge.
REQ-017 m_edge  output  8  edge magnitude.
REQ-018 m_sof  output  1  qualifies first edge of frame.
REQ-019 m_eof  output  1  qualifies last edge of frame.

Function
REQ-020 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start; RUN->FLUSH on acceptance of pixel IMG_W*IMG_H; FLUSH->DONE after PIPE_LAT flush strobes; DONE->IDLE next cycle with done=1 for that cycle.
REQ-021 Advance condition adv = (!m_valid || m_ready); s_ready = RUN && adv.
REQ-022 pix_en = (s_valid && s_ready) in RUN; pix_en = adv in FLUSH, pix_out=0 during flush; pix_en=0 in IDLE/DONE.
REQ-023 pix_out is combinational pass-through of s_pixel when accepted.
REQ-024 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) increment per accepted pixel; col wraps to 0 and row increments at col=IMG_W-1; both clear on entry to RUN.
REQ-025 Accepted pixel tagged interior iff row>=2 && col>=2; tag enters a PIPE_LAT-deep shift register advanced only on pix_en.
REQ-026 When a tag exits the shift register with pix_en, m_edge<=edge_in and m_valid<=1; m_valid clears on m_ready handshake without new tag.
REQ-027 Exactly (IMG_W-2)*(IMG_H-2) edges per frame; m_sof on first, m_eof on last; both low otherwise.
REQ-028 m_valid, m_edge, m_sof, m_eof held stable while m_valid && !m_ready.
REQ-029 Back-to-back: output handshake and new tag exit in same cycle load next edge with m_valid staying 1.
REQ-030 start outside IDLE ignored; s_valid outside RUN ignored (s_ready=0).
REQ-031 Stalls by s_valid=0 or m_ready=0 never lose or duplicate edges.

Reset
REQ-032 rst low asynchronously forces IDLE, counters 0, tag register 0, busy=0, done=0, s_ready=0, pix_en=0, pix_out=0, m_valid=0, m_edge=0, m_sof=0, m_eof=0.
REQ-033 Reset mid-frame discards all in-flight pixels and edges; next start begins a clean frame.

Configuration
REQ-034 Macro SOBEL_CTRL_FRAME_CNT_EN defined: adds output frame_cnt (16 bits, reset 0), incremented on each done pulse, wraps 0xFFFF->0.
REQ-035 Macro undefined: frame_cnt port and logic absent; all other behaviour identical.

Verification (IMG_W=4, IMG_H=4, PIPE_LAT=2 unless noted)
REQ-036 start, 16 pixels 0x00..0x0F with s_valid=1, m_ready=1 -> exactly 4 m_valid edges, m_sof on 1st, m_eof on 4th, done one pulse, busy low after.
REQ-037 Same frame, m_ready=0 after first edge for 10 cycles -> s_ready=0, pix_en=0, m_edge held, all 4 edges delivered in order.
REQ-038 s_valid toggled every other cycle -> pix_en only on accepted cycles, 4 edges, values match reference Sobel model.
REQ-039 rst low after 7 pixels, then start and full frame -> no edge from aborted frame, 4 edges from new frame, m_sof correct.
REQ-040 start pulsed during RUN -> ignored; frame completes with 4 edges and one done.
REQ-041 SOBEL_CTRL_FRAME_CNT_EN defined, three frames -> frame_cnt=3.
